qspi_flash_rsp: RTL and testbench

Synthesizable QSPI serial-flash responder. It drives the SoC's QSPI pads (sck, cs_0, dq_0..3) from the flash side, so the XIP/boot path can run against a realistic far end instead of tied-off inputs. It oversamples SCK and CS_n on the system clock and decodes READ (0x03), QUAD OUTPUT READ (0x6B) and READ JEDEC ID (0x9F). Data bytes are fetched through a simple byte-wide memory read port, to be backed by a bench memory or ROM.

---
 rtl/qspi_flash_rsp.sv | 243 ++++++++++++++++++++++++
 tb/tb_qspi_flash_rsp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_rsp.sv
// rtl/qspi_flash_rsp.sv - QSPI serial-flash responder: READ (03), QUAD OUTPUT READ (6B), JEDEC ID (9F)
// SCK/CS_n are oversampled on sys_clk; data bytes come from a byte-wide memory read port.
module qspi_flash_rsp #(
   parameter int          ADDR_W    = 24,
   parameter logic [23:0] JEDEC_ID  = 24'hEF4017,
   parameter int          DUMMY_CYC = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              qspi_sck_i,
   input  logic              qspi_cs_n_i,
   input  logic [3:0]        qspi_dq_i,
   output logic [3:0]        qspi_dq_o,
   output logic [3:0]        qspi_dq_oe,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              cmd_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA1, S_DATA4, S_ID, S_IGNORE
   } state_t;

   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_QREAD   = 8'h6B;
   localparam logic [7:0] OP_RDID    = 8'h9F;
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_sck_sync, r_cs_sync, r_dq0_sync;
   logic                r_sck_d, r_cs_d;
   logic [7:0]          r_bit_cnt;
   logic [2:0]          r_bit_idx;
   logic [7:0]          r_cmd;
   logic [ADDR_W-1:0]   r_addr_sh, r_addr_cnt, r_mem_addr;
   logic [7:0]          r_out_sh, r_hold;
   logic [1:0]          r_id_idx;
   logic                r_mem_rd, r_rd_pend, r_rd_to_hold, r_cmd_err;
   logic [3:0]          r_dq_o, r_dq_oe;

   logic                w_dq0, w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic                w_rise, w_fall, w_cmd_done, w_addr_done, w_dummy_done, w_prefetch;
   logic [7:0]          w_cmd_next;
   logic [ADDR_W-1:0]   w_addr_next, w_addr_inc;
   logic                w_unused_dq;

   assign w_unused_dq  = ^qspi_dq_i[3:1];
   assign w_dq0        = r_dq0_sync[1];
   assign w_sck_rise   = r_sck_sync[1] & ~r_sck_d;
   assign w_sck_fall   = ~r_sck_sync[1] & r_sck_d;
   assign w_cs_rise    = r_cs_sync[1] & ~r_cs_d;
   assign w_cs_fall    = ~r_cs_sync[1] & r_cs_d;
   // A CS_n release masks any SCK edge seen in the same cycle.
   assign w_rise       = w_sck_rise & ~w_cs_rise;
   assign w_fall       = w_sck_fall & ~w_cs_rise;
   assign w_cmd_next   = {r_cmd[6:0], w_dq0};
   assign w_addr_next  = {r_addr_sh[ADDR_W-2:0], w_dq0};
   assign w_addr_inc   = r_addr_cnt + 1'b1;
   assign w_cmd_done   = w_rise && (r_bit_cnt == 8'd7);
   assign w_addr_done  = w_rise && (r_bit_cnt == ADDR_LAST);
   assign w_dummy_done = w_rise && (r_bit_cnt == DUMMY_LAST);
   assign w_prefetch   = w_fall && (r_bit_idx == 3'd0) && (r_state == S_DATA1 || r_state == S_DATA4);

   assign qspi_dq_o  = r_dq_o;
   assign qspi_dq_oe = r_dq_oe;
   assign mem_rd     = r_mem_rd;
   assign mem_addr   = r_mem_addr;
   assign busy       = ~r_cs_sync[1];
   assign cmd_err    = r_cmd_err;

   function automatic logic [7:0] id_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         default: id_byte = JEDEC_ID[7:0];
      endcase
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sck_sync <= 2'b00;
         r_cs_sync  <= 2'b11;
         r_dq0_sync <= 2'b00;
         r_sck_d    <= 1'b0;
         r_cs_d     <= 1'b1;
      end else begin
         r_sck_sync <= {r_sck_sync[0], qspi_sck_i};
         r_cs_sync  <= {r_cs_sync[0], qspi_cs_n_i};
         r_dq0_sync <= {r_dq0_sync[0], qspi_dq_i[0]};
         r_sck_d    <= r_sck_sync[1];
         r_cs_d     <= r_cs_sync[1];
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_cs_rise) begin
         w_state_nxt = S_IDLE;
      end else if (w_cs_fall) begin
         w_state_nxt = S_CMD;
      end else begin
         case (r_state)
            S_CMD: begin
               if (w_cmd_done) begin
                  case (w_cmd_next)
                     OP_READ, OP_QREAD: w_state_nxt = S_ADDR;
                     OP_RDID:           w_state_nxt = S_ID;
                     default:           w_state_nxt = S_IGNORE;
                  endcase
               end
            end
            S_ADDR: begin
               if (w_addr_done) begin
                  if (r_cmd == OP_QREAD) w_state_nxt = (DUMMY_CYC == 0) ? S_DATA4 : S_DUMMY;
                  else                   w_state_nxt = S_DATA1;
               end
            end
            S_DUMMY: if (w_dummy_done) w_state_nxt = S_DATA4;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_bit_cnt    <= '0;
         r_bit_idx    <= '0;
         r_cmd        <= '0;
         r_addr_sh    <= '0;
         r_addr_cnt   <= '0;
         r_mem_addr   <= '0;
         r_out_sh     <= '0;
         r_hold       <= '0;
         r_id_idx     <= '0;
         r_mem_rd     <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_rd_to_hold <= 1'b0;
         r_cmd_err    <= 1'b0;
         r_dq_o       <= '0;
         r_dq_oe      <= '0;
      end else begin
         r_mem_rd  <= 1'b0;
         r_cmd_err <= 1'b0;
         // A read already on the bus when CS_n rises still completes, but its data is dropped.
         r_rd_pend <= r_mem_rd & ~w_cs_rise;
         if (w_cs_rise) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_dq_oe   <= '0;
            r_dq_o    <= '0;
         end else if (w_cs_fall) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_cmd     <= '0;
         end else begin
            case (r_state)
               S_CMD: begin
                  if (w_rise) begin
                     r_cmd     <= w_cmd_next;
                     r_bit_cnt <= w_cmd_done ? 8'd0 : r_bit_cnt + 8'd1;
                     if (w_cmd_done) begin
                        r_bit_idx <= '0;
                        r_cmd_err <= !(w_cmd_next inside {OP_READ, OP_QREAD, OP_RDID});
                        if (w_cmd_next == OP_RDID) begin
                           r_out_sh <= id_byte(2'd0);
                           r_id_idx <= 2'd1;
                        end
                     end
                  end
               end
               S_ADDR: begin
                  if (w_rise) begin
                     r_addr_sh <= w_addr_next;
                     if (w_addr_done) begin
                        r_bit_cnt    <= '0;
                        r_bit_idx    <= '0;
                        r_addr_cnt   <= w_addr_next;
                        r_mem_addr   <= w_addr_next;
                        r_mem_rd     <= 1'b1;
                        r_rd_to_hold <= 1'b0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                     end
                  end
               end
               S_DUMMY: if (w_rise) r_bit_cnt <= r_bit_cnt + 8'd1;
               S_DATA1, S_ID: begin
                  if (w_fall) begin
                     r_dq_oe <= 4'b0010;
                     r_dq_o  <= {2'b00, r_out_sh[7], 1'b0};
                     if (r_bit_idx == 3'd7) begin
                        r_bit_idx <= '0;
                        if (r_state == S_ID) begin
                           r_out_sh <= id_byte(r_id_idx);
                           r_id_idx <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
                        end else begin
                           r_out_sh <= r_hold;
                        end
                     end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_out_sh  <= {r_out_sh[6:0], 1'b0};
                     end
                  end
               end
               S_DATA4: begin
                  if (w_fall) begin
                     r_dq_oe <= 4'hF;
                     r_dq_o  <= r_out_sh[7:4];
                     if (r_bit_idx == 3'd0) begin
                        r_bit_idx <= 3'd1;
                        r_out_sh  <= {r_out_sh[3:0], 4'h0};
                     end else begin
                        r_bit_idx <= 3'd0;
                        r_out_sh  <= r_hold;
                     end
                  end
               end
               default: ;
            endcase
            // Fetch the following byte while the current one is still shifting out.
            if (w_prefetch) begin
               r_addr_cnt   <= w_addr_inc;
               r_mem_addr   <= w_addr_inc;
               r_mem_rd     <= 1'b1;
               r_rd_to_hold <= 1'b1;
            end
            if (r_rd_pend && (r_state inside {S_DUMMY, S_DATA1, S_DATA4})) begin
               if (r_rd_to_hold) r_hold   <= mem_rdata;
               else              r_out_sh <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_qspi_flash_rsp.sv
// tb/tb_qspi_flash_rsp.sv - scoreboard bench for qspi_flash_rsp
`timescale 1ns/1ps
module tb_qspi_flash_rsp;
   localparam int H = 8;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        qspi_sck_i = 1'b0;
   logic        qspi_cs_n_i = 1'b1;
   logic [3:0]  qspi_dq_i = 4'h0;
   logic [3:0]  qspi_dq_o, qspi_dq_oe;
   logic        mem_rd;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        busy, cmd_err;

   int          n_pass = 0;
   int          n_total = 0;
   int          err_cnt = 0;
   int          oe_bad = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [23:0] rd_q[$];

   qspi_flash_rsp #(.ADDR_W(24), .JEDEC_ID(24'hEF4017), .DUMMY_CYC(8)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .qspi_sck_i(qspi_sck_i), .qspi_cs_n_i(qspi_cs_n_i),
      .qspi_dq_i(qspi_dq_i), .qspi_dq_o(qspi_dq_o), .qspi_dq_oe(qspi_dq_oe), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) mem_rdata <= mem_rd ? (mem_addr[7:0] ^ 8'hA5) : 8'h00;

   always @(negedge sys_clk) begin
      if (mem_rd) rd_q.push_back(mem_addr);
      if (cmd_err) err_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run not finished, got timeout, required completion");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic sck_pulse(input logic mosi, output logic [3:0] dq, output logic [3:0] oe);
      qspi_sck_i   = 1'b0;
      qspi_dq_i[0] = mosi;
      wait_clk(H);
      dq = qspi_dq_o;
      oe = qspi_dq_oe;
      qspi_sck_i = 1'b1;
      wait_clk(H);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr, input int n_addr, input int n_dummy);
      logic [3:0] dq, oe;
      qspi_cs_n_i = 1'b0;
      wait_clk(H);
      for (int i = 7; i >= 0; i--) begin
         sck_pulse(cmd[i], dq, oe);
         if (oe !== 4'h0) oe_bad++;
      end
      for (int i = 0; i < n_addr; i++) begin
         sck_pulse(addr[23-i], dq, oe);
         if (oe !== 4'h0) oe_bad++;
      end
      for (int i = 0; i < n_dummy; i++) begin
         sck_pulse(1'b0, dq, oe);
         if (oe !== 4'h0) oe_bad++;
      end
   endtask

   task automatic recv_bytes(input int n, input bit quad);
      logic [3:0] dq, oe;
      logic [7:0] b;
      for (int k = 0; k < n; k++) begin
         b = 8'h00;
         if (quad) begin
            for (int j = 0; j < 2; j++) begin
               sck_pulse(1'b0, dq, oe);
               b = {b[3:0], dq};
               if (oe !== 4'hF) oe_bad++;
            end
         end else begin
            for (int j = 0; j < 8; j++) begin
               sck_pulse(1'b0, dq, oe);
               b = {b[6:0], dq[1]};
               if (oe !== 4'b0010) oe_bad++;
            end
         end
         got_q.push_back(b);
      end
   endtask

   task automatic end_xfer();
      qspi_sck_i  = 1'b0;
      qspi_cs_n_i = 1'b1;
      wait_clk(2 * H);
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      rd_q.delete();
      oe_bad  = 0;
      err_cnt = 0;
   endtask

   task automatic test_reset();
      wait_clk(2);
      n_total++;
      if ({qspi_dq_o, qspi_dq_oe, mem_rd, busy, cmd_err, mem_addr} !== 35'd0)
         $display("FAIL reset_hold: outputs %h, required 0", {qspi_dq_o, qspi_dq_oe, mem_rd, busy, cmd_err, mem_addr});
      else n_pass++;
      sys_rst_n = 1'b1;
      wait_clk(6);
      n_total++;
      if ({qspi_dq_o, qspi_dq_oe, mem_rd, busy, cmd_err, mem_addr} !== 35'd0)
         $display("FAIL reset_idle: outputs %h, required 0", {qspi_dq_o, qspi_dq_oe, mem_rd, busy, cmd_err, mem_addr});
      else n_pass++;
   endtask

   task automatic test_single_read();
      logic [7:0] e, g;
      clear_sb();
      exp_q.push_back(8'hB5);
      exp_q.push_back(8'hB4);
      send_hdr(8'h03, 24'h000010, 24, 0);
      recv_bytes(2, 1'b0);
      end_xfer();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_total++;
         if (g !== e) $display("FAIL single_read byte: got %h, required %h", g, e); else n_pass++;
      end
      n_total++;
      if (oe_bad !== 0) $display("FAIL single_read oe: bad samples %0d, required 0", oe_bad); else n_pass++;
      n_total++;
      if (rd_q[0] !== 24'h000010) $display("FAIL single_read rd0: got %h, required 000010", rd_q[0]); else n_pass++;
      n_total++;
      if (rd_q[1] !== 24'h000011) $display("FAIL single_read rd1: got %h, required 000011", rd_q[1]); else n_pass++;
      n_total++;
      if (err_cnt !== 0) $display("FAIL single_read cmd_err: got %0d pulses, required 0", err_cnt); else n_pass++;
      n_total++;
      if (qspi_dq_oe !== 4'h0) $display("FAIL single_read oe_after: got %b, required 0000", qspi_dq_oe); else n_pass++;
   endtask

   task automatic test_quad_read();
      logic [7:0] e, g;
      clear_sb();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hA4);
      send_hdr(8'h6B, 24'h000100, 24, 8);
      recv_bytes(2, 1'b1);
      end_xfer();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_total++;
         if (g !== e) $display("FAIL quad_read byte: got %h, required %h", g, e); else n_pass++;
      end
      n_total++;
      if (oe_bad !== 0) $display("FAIL quad_read oe: bad samples %0d, required 0", oe_bad); else n_pass++;
      n_total++;
      if (rd_q[0] !== 24'h000100) $display("FAIL quad_read rd0: got %h, required 000100", rd_q[0]); else n_pass++;
      n_total++;
      if (rd_q[1] !== 24'h000101) $display("FAIL quad_read rd1: got %h, required 000101", rd_q[1]); else n_pass++;
   endtask

   task automatic test_read_id(input int n);
      logic [7:0] e, g;
      logic [7:0] ids [3];
      ids = '{8'hEF, 8'h40, 8'h17};
      clear_sb();
      for (int i = 0; i < n; i++) exp_q.push_back(ids[i % 3]);
      send_hdr(8'h9F, 24'h0, 0, 0);
      recv_bytes(n, 1'b0);
      end_xfer();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_total++;
         if (g !== e) $display("FAIL read_id byte: got %h, required %h", g, e); else n_pass++;
      end
      n_total++;
      if (oe_bad !== 0) $display("FAIL read_id oe: bad samples %0d, required 0", oe_bad); else n_pass++;
      n_total++;
      if (rd_q.size() !== 0) $display("FAIL read_id mem_rd: got %0d reads, required 0", rd_q.size()); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0] e, g;
      clear_sb();
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hA5);
      send_hdr(8'h03, 24'hFFFFFF, 24, 0);
      recv_bytes(2, 1'b0);
      end_xfer();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_total++;
         if (g !== e) $display("FAIL wrap byte: got %h, required %h", g, e); else n_pass++;
      end
      n_total++;
      if (rd_q[0] !== 24'hFFFFFF) $display("FAIL wrap rd0: got %h, required FFFFFF", rd_q[0]); else n_pass++;
      n_total++;
      if (rd_q[1] !== 24'h000000) $display("FAIL wrap rd1: got %h, required 000000", rd_q[1]); else n_pass++;
   endtask

   task automatic test_abort();
      logic [3:0] dq, oe;
      clear_sb();
      send_hdr(8'h03, 24'h123456, 13, 0);
      n_total++;
      if (busy !== 1'b1) $display("FAIL abort busy_mid: got %b, required 1", busy); else n_pass++;
      qspi_sck_i  = 1'b0;
      qspi_cs_n_i = 1'b1;
      wait_clk(3);
      n_total++;
      if ({busy, qspi_dq_oe} !== 5'b0) $display("FAIL abort addr: busy/oe %b, required 00000", {busy, qspi_dq_oe}); else n_pass++;
      wait_clk(2 * H);
      send_hdr(8'h03, 24'h000020, 24, 0);
      for (int i = 0; i < 5; i++) sck_pulse(1'b0, dq, oe);
      qspi_sck_i  = 1'b0;
      qspi_cs_n_i = 1'b1;
      wait_clk(2);
      n_total++;
      if (qspi_dq_oe !== 4'b0010) $display("FAIL abort data_lat2: oe %b, required 0010", qspi_dq_oe); else n_pass++;
      wait_clk(1);
      n_total++;
      if (qspi_dq_oe !== 4'b0000) $display("FAIL abort data_lat3: oe %b, required 0000", qspi_dq_oe); else n_pass++;
      wait_clk(2 * H);
      test_read_id(3);
   endtask

   task automatic test_bad_opcode();
      logic [3:0] dq, oe;
      clear_sb();
      send_hdr(8'h55, 24'h0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         sck_pulse(1'b1, dq, oe);
         if (oe !== 4'h0) oe_bad++;
      end
      end_xfer();
      n_total++;
      if (err_cnt !== 1) $display("FAIL bad_opcode cmd_err: got %0d pulses, required 1", err_cnt); else n_pass++;
      n_total++;
      if (oe_bad !== 0) $display("FAIL bad_opcode oe: bad samples %0d, required 0", oe_bad); else n_pass++;
   endtask

   task automatic test_reset_mid_data4();
      logic [3:0] dq, oe;
      logic [7:0] e, g;
      clear_sb();
      send_hdr(8'h6B, 24'h000100, 24, 8);
      sck_pulse(1'b0, dq, oe);
      sys_rst_n = 1'b0;
      wait_clk(1);
      n_total++;
      if ({qspi_dq_o, qspi_dq_oe, mem_rd, busy, cmd_err, mem_addr} !== 35'd0)
         $display("FAIL reset_mid outputs: got %h, required 0", {qspi_dq_o, qspi_dq_oe, mem_rd, busy, cmd_err, mem_addr});
      else n_pass++;
      qspi_sck_i  = 1'b0;
      qspi_cs_n_i = 1'b1;
      wait_clk(1);
      sys_rst_n = 1'b1;
      wait_clk(2 * H);
      clear_sb();
      exp_q.push_back(8'h65);
      exp_q.push_back(8'h64);
      send_hdr(8'h6B, 24'h0003C0, 24, 8);
      recv_bytes(2, 1'b1);
      end_xfer();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         n_total++;
         if (g !== e) $display("FAIL reset_mid byte: got %h, required %h", g, e); else n_pass++;
      end
      n_total++;
      if (oe_bad !== 0) $display("FAIL reset_mid oe: bad samples %0d, required 0", oe_bad); else n_pass++;
   endtask

   initial begin
      @(negedge sys_clk);
      test_reset();
      test_single_read();
      test_quad_read();
      test_read_id(4);
      test_wrap();
      test_abort();
      test_bad_opcode();
      test_reset_mid_data4();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
